// File: rtl/ysyx_25050148_dmem_ctrl.sv
// rtl/ysyx_25050148_dmem_ctrl.sv - latency-configurable data memory with valid/ready request and response
module ysyx_25050148_dmem_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter int                LATENCY   = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,         // synchronous, active-high
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,     // 1 = store, 0 = load
    input  logic [1:0]        req_size,    // 0 byte, 1 half, 2 word, 3 reserved
    input  logic              req_signed,  // load extension select
    input  logic [ADDR_W-1:0] req_addr,    // byte address
    input  logic [31:0]       req_wdata,   // right-aligned store data
    // response channel
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,  // extended load data, 0 for stores/errors
    output logic              resp_err
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int CNT_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              l_wen;
    logic [1:0]        l_size;
    logic              l_signed;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;

    logic [31:0]       mem [DEPTH];

    // With LATENCY = 0 the commit happens on the accept edge, so the
    // operands come straight from the request port instead of the latches.
    logic              c_wen;
    logic [1:0]        c_size;
    logic              c_signed;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic              commit;

    always_comb begin
        c_wen    = (state == IDLE) ? req_wen    : l_wen;
        c_size   = (state == IDLE) ? req_size   : l_size;
        c_signed = (state == IDLE) ? req_signed : l_signed;
        c_addr   = (state == IDLE) ? req_addr   : l_addr;
        c_wdata  = (state == IDLE) ? req_wdata  : l_wdata;
        if (LATENCY == 0) begin
            commit = (state == IDLE) && req_valid;
        end else begin
            commit = (state == WAIT) && (cnt == '0);
        end
    end

    assign req_ready = (state == IDLE) && !rst;

    // BASE_ADDR is word-aligned, so the word offset is formed from the
    // upper address bits only; the lane bits come from c_addr directly.
    logic [ADDR_W-3:0] off_w;
    logic [IDX_W-1:0]  idx;
    logic              below, out_range, misalign, err;

    always_comb begin
        off_w     = c_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
        idx       = off_w[IDX_W-1:0];
        below     = c_addr < BASE_ADDR;
        out_range = |off_w[ADDR_W-3:IDX_W];
        misalign  = (c_size == 2'd3) ||
                    ((c_size == 2'd1) && c_addr[0]) ||
                    ((c_size == 2'd2) && (c_addr[1:0] != 2'b00));
        err       = misalign || below || out_range;
    end

    // Store lane enables and replicated store data.
    logic [3:0]  be;
    logic [31:0] wd_lanes;

    always_comb begin
        be       = 4'b0000;
        wd_lanes = c_wdata;
        case (c_size)
            2'd0: begin
                be       = 4'b0001 << c_addr[1:0];
                wd_lanes = {4{c_wdata[7:0]}};
            end
            2'd1: begin
                be       = c_addr[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{c_wdata[15:0]}};
            end
            2'd2: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Load path: align the addressed lane to bit 0, then extend.
    logic [31:0] rd_word, rd_shift, rd_ext, rd_final;

    always_comb begin
        rd_word  = mem[idx];
        rd_shift = rd_word >> {c_addr[1:0], 3'b000};
        case (c_size)
            2'd0:    rd_ext = c_signed ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                       : {24'b0, rd_shift[7:0]};
            2'd1:    rd_ext = c_signed ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                       : {16'b0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
        rd_final = (c_wen || err) ? 32'h0 : rd_ext;
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_wen && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wd_lanes[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_wen    <= req_wen;
                        l_size   <= req_size;
                        l_signed <= req_signed;
                        l_addr   <= req_addr;
                        l_wdata  <= req_wdata;
                        cnt      <= CNT_W'(CNT_INIT);
                        if (LATENCY == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rd_final;
                            resp_err   <= err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rd_final;
                        resp_err   <= err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25050148_dmem_ctrl.sv
// tb/tb_ysyx_25050148_dmem_ctrl.sv - scoreboard bench for dmem_ctrl at LATENCY 2, 0 and 3
module tb_ysyx_25050148_dmem_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_wen    [3];
    logic [1:0]  req_size   [3];
    logic        req_signed [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int lat [3] = '{2, 0, 3};

    always #5 clk = ~clk;

    ysyx_25050148_dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .LATENCY(2), .BASE_ADDR(BASE)) u_l2 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_wen(req_wen[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    ysyx_25050148_dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .LATENCY(0), .BASE_ADDR(BASE)) u_l0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_wen(req_wen[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    ysyx_25050148_dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_wen(req_wen[2]), .req_size(req_size[2]), .req_signed(req_signed[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
        .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

    typedef struct {
        int          k;
        logic [31:0] rdata;
        logic        err;
        int          rise;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    logic prev_v [3] = '{1'b0, 1'b0, 1'b0};
    int   rise_e [3] = '{0, 0, 0};

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: samples 1ns after the falling edge; a response is consumed at
    // the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        exp_t e;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (resp_valid[k] && !prev_v[k]) rise_e[k] = edge_n;
            prev_v[k] = resp_valid[k];
            if (resp_valid[k] && resp_ready[k]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp dut%0d: got rdata %h err %b want none", k, resp_rdata[k], resp_err[k]);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, ".dut"}, k, e.k);
                    chk({e.name, ".rdata"}, resp_rdata[k], e.rdata);
                    chk({e.name, ".err"}, {31'b0, resp_err[k]}, {31'b0, e.err});
                    chk({e.name, ".rise_edge"}, rise_e[k], e.rise);
                end
            end
        end
    end

    task automatic issue(input int k, input logic wen, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit expect_resp,
                         input logic [31:0] er, input logic ee, input string nm);
        int n = 0;
        while (!req_ready[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            checks++;
            errors++;
            $display("FAIL %s.accept: got req_ready 0 want 1", nm);
            return;
        end
        req_wen[k]    = wen;
        req_size[k]   = sz;
        req_signed[k] = sg;
        req_addr[k]   = a;
        req_wdata[k]  = wd;
        req_valid[k]  = 1'b1;
        if (expect_resp) sb.push_back('{k, er, ee, edge_n + 1 + lat[k], nm});
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got %0d pending want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic xact(input int k, input logic wen, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input string nm);
        issue(k, wen, sz, sg, a, wd, 1'b1, er, ee, nm);
        wait_idle(nm);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_size[k] = 2'd0;
            req_signed[k] = 1'b0; req_addr[k] = 32'h0; req_wdata[k] = 32'h0; resp_ready[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d.req_ready", k), {31'b0, req_ready[k]}, 32'h0);
            chk($sformatf("rst%0d.resp_valid", k), {31'b0, resp_valid[k]}, 32'h0);
            chk($sformatf("rst%0d.resp_rdata", k), resp_rdata[k], 32'h0);
            chk($sformatf("rst%0d.resp_err", k), {31'b0, resp_err[k]}, 32'h0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("idle%0d.req_ready", k), {31'b0, req_ready[k]}, 32'h1);
        @(negedge clk);

        // LATENCY = 2: lane steering, extension and error cases
        xact(0, 1, 2'd2, 0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, "st_w");
        xact(0, 0, 2'd2, 0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, "ld_w");
        xact(0, 1, 2'd0, 0, 32'h8000_0012, 32'h0000_0080, 32'h0, 0, "st_b");
        xact(0, 0, 2'd0, 1, 32'h8000_0012, 32'h0, 32'hFFFF_FF80, 0, "ld_bs");
        xact(0, 0, 2'd0, 0, 32'h8000_0012, 32'h0, 32'h0000_0080, 0, "ld_bu");
        xact(0, 0, 2'd2, 0, 32'h8000_0010, 32'h0, 32'hDE80_BEEF, 0, "ld_w2");
        xact(0, 0, 2'd1, 1, 32'h8000_0012, 32'h0, 32'hFFFF_DE80, 0, "ld_hs");
        xact(0, 0, 2'd1, 0, 32'h8000_0011, 32'h0, 32'h0, 1, "ld_h_mis");
        xact(0, 1, 2'd1, 0, 32'h8000_0011, 32'h1234, 32'h0, 1, "st_h_mis");
        xact(0, 0, 2'd2, 0, 32'h8000_0010, 32'h0, 32'hDE80_BEEF, 0, "ld_w3");
        xact(0, 1, 2'd2, 0, 32'h8000_0000, 32'h1234_5678, 32'h0, 0, "st_w0");
        xact(0, 1, 2'd2, 0, 32'h8000_1000, 32'h9999_9999, 32'h0, 1, "st_oor");
        xact(0, 0, 2'd2, 0, 32'h8000_0000, 32'h0, 32'h1234_5678, 0, "ld_w0");
        xact(0, 1, 2'd3, 0, 32'h8000_0010, 32'h0, 32'h0, 1, "st_sz3");
        xact(0, 0, 2'd2, 0, 32'h7FFF_FFFC, 32'h0, 32'h0, 1, "ld_below");
        xact(0, 0, 2'd2, 0, 32'h8000_0012, 32'h0, 32'h0, 1, "ld_w_mis");
        xact(0, 1, 2'd1, 0, 32'h8000_0012, 32'hFFFF_CAFE, 32'h0, 0, "st_h");
        xact(0, 0, 2'd1, 0, 32'h8000_0012, 32'h0, 32'h0000_CAFE, 0, "ld_hu");
        xact(0, 0, 2'd0, 1, 32'h8000_0013, 32'h0, 32'hFFFF_FFCA, 0, "ld_bs3");
        xact(0, 0, 2'd0, 0, 32'h8000_0011, 32'h0, 32'h0000_00BE, 0, "ld_bu1");
        xact(0, 1, 2'd0, 0, 32'h8000_0011, 32'h1234_5677, 32'h0, 0, "st_b1");
        xact(0, 0, 2'd2, 1, 32'h8000_0010, 32'h0, 32'hCAFE_77EF, 0, "ld_ws");

        // Backpressure: response held, new requests ignored
        resp_ready[0] = 1'b0;
        issue(0, 0, 2'd2, 0, 32'h8000_0010, 32'h0, 1'b1, 32'hCAFE_77EF, 0, "bp");
        n = 0;
        while (!resp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_wen[0] = 1'b1; req_size[0] = 2'd2; req_addr[0] = 32'h8000_0010;
        req_wdata[0] = 32'hFFFF_FFFF; req_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("bp.hold_valid", {31'b0, resp_valid[0]}, 32'h1);
            chk("bp.hold_rdata", resp_rdata[0], 32'hCAFE_77EF);
            chk("bp.hold_err", {31'b0, resp_err[0]}, 32'h0);
            chk("bp.req_ready", {31'b0, req_ready[0]}, 32'h0);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        #1;
        chk("bp.release_ready", {31'b0, req_ready[0]}, 32'h1);
        chk("bp.release_valid", {31'b0, resp_valid[0]}, 32'h0);
        wait_idle("bp");
        @(negedge clk);
        xact(0, 0, 2'd2, 0, 32'h8000_0010, 32'h0, 32'hCAFE_77EF, 0, "ld_after_bp");

        // LATENCY = 0
        xact(1, 1, 2'd2, 0, 32'h8000_0004, 32'h0BAD_F00D, 32'h0, 0, "l0_st");
        xact(1, 0, 2'd1, 1, 32'h8000_0006, 32'h0, 32'h0000_0BAD, 0, "l0_ld_hs");
        xact(1, 0, 2'd0, 1, 32'h8000_0005, 32'h0, 32'hFFFF_FFF0, 0, "l0_ld_bs");
        xact(1, 0, 2'd0, 1, 32'h8000_0004, 32'h0, 32'h0000_000D, 0, "l0_ld_bs0");
        xact(1, 1, 2'd2, 0, 32'h8000_0FFC, 32'h5555_AAAA, 32'h0, 0, "l0_st_last");
        xact(1, 0, 2'd2, 0, 32'h8000_0FFC, 32'h0, 32'h5555_AAAA, 0, "l0_ld_last");

        // LATENCY = 3: reset during WAIT, and on the commit edge
        xact(2, 1, 2'd2, 0, 32'h8000_0020, 32'h1111_1111, 32'h0, 0, "l3_st");
        issue(2, 1, 2'd2, 0, 32'h8000_0020, 32'h2222_2222, 1'b0, 32'h0, 0, "l3_rst_wait");
        rst[2] = 1'b1;
        #1;
        chk("l3_rst_wait.req_ready", {31'b0, req_ready[2]}, 32'h0);
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        chk("l3_rst_wait.resp_valid", {31'b0, resp_valid[2]}, 32'h0);
        chk("l3_rst_wait.req_ready_after", {31'b0, req_ready[2]}, 32'h1);
        @(negedge clk);
        xact(2, 0, 2'd2, 0, 32'h8000_0020, 32'h0, 32'h1111_1111, 0, "l3_ld_old");
        issue(2, 1, 2'd2, 0, 32'h8000_0020, 32'h3333_3333, 1'b0, 32'h0, 0, "l3_rst_commit");
        repeat (2) @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        chk("l3_rst_commit.resp_valid", {31'b0, resp_valid[2]}, 32'h0);
        @(negedge clk);
        xact(2, 0, 2'd2, 0, 32'h8000_0020, 32'h0, 32'h1111_1111, 0, "l3_ld_old2");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
